// File: rtl/odesa_pkg.sv
// Shared ODESA definitions: neuron count, FSM encoding and the packing helpers
// used by both the layer-2 neuron block and L2_train.
package odesa_pkg;

    localparam int NEURONS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_DOT  = 2'd2,
        ST_CMP  = 2'd3
    } state_t;

    // Dot-product width for a given surface/weight width.
    function automatic int lv_width(input int w);
        return 2 * w + 1;
    endfunction

    // Slot n (1-based) of the weight bus is {w2[n], w1[n]}, w1 in the low half.
    function automatic int w1_lsb(input int n, input int w);
        return (n - 1) * 2 * w;
    endfunction

    function automatic int w2_lsb(input int n, input int w);
        return (n - 1) * 2 * w + w;
    endfunction

    // Same slot layout serves thresholds and dot products.
    function automatic int thr_lsb(input int n, input int w);
        return (n - 1) * (2 * w + 1);
    endfunction

endpackage

// File: rtl/odesa_wta4.sv
// Threshold compare plus argmax over four neurons; ties resolve to the lowest
// index, and no candidate yields an all-zero result.
module odesa_wta4
    import odesa_pkg::*;
#(
    parameter int p_lv_width = 19
) (
    input  logic [NEURONS*p_lv_width-1:0] lv,
    input  logic [NEURONS*p_lv_width-1:0] thr,
    output logic [NEURONS:1]              win
);

    logic                  found;
    logic [p_lv_width-1:0] best;
    logic [p_lv_width-1:0] cur;
    logic [p_lv_width-1:0] cur_thr;

    always_comb begin
        win     = '0;
        found   = 1'b0;
        best    = '0;
        cur     = '0;
        cur_thr = '0;
        // Strict '>' keeps the earlier (lower) index on equal values.
        for (int n = 1; n <= NEURONS; n++) begin
            cur     = lv[(n-1)*p_lv_width +: p_lv_width];
            cur_thr = thr[(n-1)*p_lv_width +: p_lv_width];
            if (cur >= cur_thr && (!found || cur > best)) begin
                found  = 1'b1;
                best   = cur;
                win    = '0;
                win[n] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_neuron_layer.sv
// Layer-2 inference: decaying two-channel time surface, four serial dot
// products on one shared multiplier pair, then threshold + winner-take-all.
module l2_neuron_layer
    import odesa_pkg::*;
#(
    parameter int p_width = 9,
    parameter int p_decay = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [2:1]                        i_event,
    input  logic                              i_decay_tick,
    input  logic [NEURONS*2*p_width-1:0]      i_weights,
    input  logic [NEURONS*(2*p_width+1)-1:0]  i_thresholds,
    output logic [NEURONS:1]                  o_spikeout,
    output logic [2*p_width-1:0]              o_ts,
    output logic [NEURONS*(2*p_width+1)-1:0]  o_lv,
    output logic                              o_busy,
    output logic                              o_overrun,
    output state_t                            o_dbg_state
);

    localparam int LVW = lv_width(p_width);
    localparam logic [p_width-1:0] DEC    = p_width'(p_decay);
    localparam logic [p_width-1:0] TS_MAX = '1;

    state_t              state_q;
    logic [1:0]          k_q;
    logic                pending_q;
    logic [p_width-1:0]  ts1_q;
    logic [p_width-1:0]  ts2_q;
    logic [LVW-1:0]      lv_q [0:NEURONS-1];
    logic [p_width-1:0]  w1 [0:NEURONS-1];
    logic [p_width-1:0]  w2 [0:NEURONS-1];
    logic [NEURONS:1]    win;
    logic                any_ev;
    logic                go;

    assign any_ev      = |i_event;
    // IDLE sees a request on the same edge that would latch it, so SNAP
    // follows the event edge directly.
    assign go          = (state_q == ST_IDLE) && (pending_q || any_ev);
    assign o_dbg_state = state_q;

    for (genvar n = 0; n < NEURONS; n++) begin : g_slot
        assign w1[n] = i_weights[w1_lsb(n + 1, p_width) +: p_width];
        assign w2[n] = i_weights[w2_lsb(n + 1, p_width) +: p_width];
        assign o_lv[thr_lsb(n + 1, p_width) +: LVW] = lv_q[n];
    end

    // Shared multiplier pair works on the snapshot, weights of the current slot.
    logic [2*p_width-1:0] prod1;
    logic [2*p_width-1:0] prod2;
    logic [LVW-1:0]       lv_sum;

    assign prod1  = (2*p_width)'(w1[k_q]) * (2*p_width)'(o_ts[p_width-1:0]);
    assign prod2  = (2*p_width)'(w2[k_q]) * (2*p_width)'(o_ts[2*p_width-1:p_width]);
    assign lv_sum = LVW'(prod1) + LVW'(prod2);

    odesa_wta4 #(.p_lv_width(LVW)) u_wta (
        .lv  (o_lv),
        .thr (i_thresholds),
        .win (win)
    );

    // Surface runs every cycle; an event beats a decay tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts1_q <= '0;
            ts2_q <= '0;
        end else begin
            if (i_event[1])        ts1_q <= TS_MAX;
            else if (i_decay_tick) ts1_q <= (ts1_q >= DEC) ? ts1_q - DEC : '0;
            if (i_event[2])        ts2_q <= TS_MAX;
            else if (i_decay_tick) ts2_q <= (ts2_q >= DEC) ? ts2_q - DEC : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            pending_q <= go ? 1'b0 : (pending_q || any_ev);
            o_overrun <= any_ev && pending_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            o_ts       <= '0;
            o_spikeout <= '0;
            o_busy     <= 1'b0;
            for (int n = 0; n < NEURONS; n++) lv_q[n] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    o_spikeout <= '0;
                    o_busy     <= 1'b0;
                    if (go) state_q <= ST_SNAP;
                end
                ST_SNAP: begin
                    o_ts    <= {ts2_q, ts1_q};
                    k_q     <= '0;
                    o_busy  <= 1'b1;
                    state_q <= ST_DOT;
                end
                ST_DOT: begin
                    lv_q[k_q] <= lv_sum;
                    if (k_q == 2'd3) state_q <= ST_CMP;
                    else             k_q     <= k_q + 2'd1;
                end
                ST_CMP: begin
                    o_spikeout <= win;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
